i2s_transmitter: RTL and testbench

Serializes 24-bit two's-complement stereo samples from the effects chain (tremolo `D_Out` and later pedals) onto an I2S line for the codec DAC. Runs on the codec bit clock and generates the `Lrck` word-select that also clocks the effects chain. A single-entry sample buffer with a valid/ready handshake decouples sample production from frame timing. An underrun detector mutes output until fresh data arrives.

---
 rtl/i2s_transmitter_if.sv | 23 ++
 rtl/i2s_transmitter.sv | 105 ++++++++++
 tb/tb_i2s_transmitter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_transmitter_if.sv
// rtl/i2s_transmitter_if.sv - stereo sample handshake between producer and I2S transmitter
interface i2s_transmitter_if #(
    parameter int DATA_W = 24
) ();
    logic [DATA_W-1:0] D_L;
    logic [DATA_W-1:0] D_R;
    logic              D_Valid;
    logic              D_Ready;

    modport master (
        output D_L,
        output D_R,
        output D_Valid,
        input  D_Ready
    );

    modport slave (
        input  D_L,
        input  D_R,
        input  D_Valid,
        output D_Ready
    );
endinterface

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S serializer with single-entry sample buffer and underrun mute
module i2s_transmitter #(
    parameter int DATA_W = 24
) (
    input  logic              Sclk,
    input  logic              Reset,
    i2s_transmitter_if.slave  smp,
    output logic              Lrck,
    output logic              Sdata,
    output logic              Underrun
);
    localparam int PAD = 32 - DATA_W;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [5:0]          bit_cnt;
    logic [5:0]          bit_cnt_next;
    logic                buf_full;
    logic [2*DATA_W-1:0] buf_data;
    logic [63:0]         shf;
    logic [63:0]         frame_image;
    logic                accept;
    logic                boundary;
    logic                load_buf;
    logic                underrun_next;

    assign smp.D_Ready  = ~buf_full & ~Reset;
    assign accept       = smp.D_Valid & smp.D_Ready;
    assign boundary     = (bit_cnt == 6'd63);
    assign bit_cnt_next = bit_cnt + 6'd1;

    // Shf[63] is the bit for slot position 1; Sdata lags Shf by one register,
    // which produces the one-bit I2S delay after each Lrck edge.
    assign frame_image = {buf_data[2*DATA_W-1:DATA_W], {PAD{1'b0}},
                          buf_data[DATA_W-1:0],        {PAD{1'b0}}};

    always_comb begin
        state_next    = state;
        load_buf      = 1'b0;
        underrun_next = 1'b0;
        if (boundary) begin
            case (state)
                IDLE: begin
                    if (buf_full) begin
                        load_buf   = 1'b1;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (buf_full) begin
                        load_buf = 1'b1;
                    end else begin
                        underrun_next = 1'b1;
                        state_next    = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Sclk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Sclk) begin
        if (Reset) begin
            bit_cnt  <= 6'd0;
            buf_full <= 1'b0;
            buf_data <= '0;
            shf      <= '0;
            Lrck     <= 1'b0;
            Sdata    <= 1'b0;
            Underrun <= 1'b0;
        end else begin
            bit_cnt  <= bit_cnt_next;
            Lrck     <= bit_cnt_next[5];
            Sdata    <= shf[63];
            Underrun <= underrun_next;

            if (boundary) begin
                shf <= load_buf ? frame_image : 64'd0;
            end else begin
                shf <= {shf[62:0], 1'b0};
            end

            // A capture on the boundary edge wins over the clear, so the pair waits a frame.
            if (accept) begin
                buf_data <= {smp.D_L, smp.D_R};
                buf_full <= 1'b1;
            end else if (boundary) begin
                buf_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - scoreboard bench for i2s_transmitter
module tb_i2s_transmitter;
    logic Sclk = 1'b0;
    logic rst  = 1'b1;
    logic lrck, sdata, und;
    logic lrck16, sdata16, und16;

    int n_assert = 0;
    int n_fail   = 0;
    int und_cnt  = 0;
    int cyc      = 0;
    logic        run      = 1'b0;
    logic        exp_und  = 1'b0;
    logic        hs       = 1'b0;
    logic        mon_en   = 1'b0;
    logic [63:0] cur_frame = '0;
    logic [63:0] exp_q[$];

    i2s_transmitter_if #(.DATA_W(24)) bus ();
    i2s_transmitter_if #(.DATA_W(16)) bus16 ();

    i2s_transmitter #(.DATA_W(24)) dut (
        .Sclk     (Sclk),
        .Reset    (rst),
        .smp      (bus.slave),
        .Lrck     (lrck),
        .Sdata    (sdata),
        .Underrun (und)
    );

    i2s_transmitter #(.DATA_W(16)) dut16 (
        .Sclk     (Sclk),
        .Reset    (rst),
        .smp      (bus16.slave),
        .Lrck     (lrck16),
        .Sdata    (sdata16),
        .Underrun (und16)
    );

    always #5 Sclk = ~Sclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line image: index k is the Sdata value while the frame counter is k.
    function automatic logic [63:0] mkframe(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 24; i++) begin
            f[1 + i]  = l[23 - i];
            f[33 + i] = r[23 - i];
        end
        return f;
    endfunction

    always @(posedge Sclk) begin
        if (rst) begin
            cyc       <= 0;
            cur_frame <= '0;
            run       <= 1'b0;
            exp_und   <= 1'b0;
            exp_q.delete();
        end else begin
            cyc     <= (cyc == 63) ? 0 : cyc + 1;
            exp_und <= 1'b0;
            if (cyc == 63) begin
                if (exp_q.size() > 0) begin
                    cur_frame <= exp_q.pop_front();
                    run       <= 1'b1;
                end else begin
                    cur_frame <= '0;
                    exp_und   <= run;
                    run       <= 1'b0;
                end
            end
            if (hs) exp_q.push_back(mkframe(bus.D_L, bus.D_R));
        end
    end

    always @(negedge Sclk) begin
        hs <= bus.D_Valid & bus.D_Ready;
        if (mon_en) begin
            chk("lrck", 64'(lrck), 64'(cyc >= 32));
            chk("sdata", 64'(sdata), 64'(cur_frame[cyc]));
            chk("underrun", 64'(und), 64'(exp_und));
            chk("d_ready", 64'(bus.D_Ready), 64'(!rst && exp_q.size() == 0));
            if (und) und_cnt++;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Sclk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] l, input logic [23:0] r);
        int t;
        t = 0;
        @(posedge Sclk);
        #1;
        bus.D_L = l;
        bus.D_R = r;
        bus.D_Valid = 1'b1;
        @(negedge Sclk);
        while (!bus.D_Ready && t < 200) begin
            @(negedge Sclk);
            t++;
        end
        if (t >= 200) chk("send_timeout", 64'(t), 64'd0);
        @(posedge Sclk);
        #1;
        bus.D_Valid = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        int t;
        t = 0;
        while (cyc != c && t < 200) begin
            step(1);
            t++;
        end
        if (t >= 200) chk("wait_cyc_timeout", 64'(t), 64'd0);
    endtask

    initial begin
        int n;
        int caps;
        logic [15:0] l16;
        logic [15:0] r16;
        logic [63:0] exp16;
        bus.D_L = '0;
        bus.D_R = '0;
        bus.D_Valid = 1'b0;
        bus16.D_L = '0;
        bus16.D_R = '0;
        bus16.D_Valid = 1'b0;

        // Reset values, including a mid-frame reset with a pair in flight
        @(posedge Sclk);
        #1;
        mon_en = 1'b1;
        step(2);
        rst = 1'b0;
        send(24'h123456, 24'h654321);
        wait_cyc(20);
        step(64);
        rst = 1'b1;
        step(5);
        chk("rst_lrck", 64'(lrck), 64'd0);
        chk("rst_sdata", 64'(sdata), 64'd0);
        chk("rst_underrun", 64'(und), 64'd0);
        chk("rst_d_ready", 64'(bus.D_Ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_d_ready", 64'(bus.D_Ready), 64'd1);
        n = 0;
        while (!lrck && n < 100) begin
            step(1);
            n++;
        end
        chk("lrck_rise_delay", 64'(n), 64'd32);
        while (lrck && n < 200) begin
            step(1);
            n++;
        end
        chk("lrck_fall_delay", 64'(n), 64'd64);

        // Single pair from IDLE
        wait_cyc(10);
        send(24'h800001, 24'h7FFFFE);
        step(140);

        // Continuous ramp stream
        und_cnt = 0;
        for (int i = 1; i <= 8; i++) send(24'(i), 24'(-i));
        chk("stream_no_underrun", 64'(und_cnt), 64'd0);
        step(200);

        // Underrun after three frames of data
        und_cnt = 0;
        for (int i = 0; i < 3; i++) send(24'hA00000 + 24'(i), 24'h00000F - 24'(i));
        step(64 * 5);
        chk("underrun_count", 64'(und_cnt), 64'd1);
        send(24'hC0FFEE, 24'h0BADF0);
        step(64 * 3);
        chk("underrun_after_resume", 64'(und_cnt), 64'd2);

        // Backpressure with D_Valid held high
        wait_cyc(10);
        caps = 0;
        bus.D_L = 24'h111111;
        bus.D_R = 24'hEEEEEE;
        bus.D_Valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (hs) begin
                caps++;
                bus.D_L = bus.D_L + 24'h010203;
                bus.D_R = bus.D_R - 24'h030201;
            end
        end
        bus.D_Valid = 1'b0;
        chk("backpressure_captures", 64'(caps), 64'd5);
        step(64 * 3);

        // Capture on the boundary edge is held a full frame
        wait_cyc(63);
        bus.D_L = 24'h5A5A5A;
        bus.D_R = 24'hA5A5A5;
        bus.D_Valid = 1'b1;
        step(1);
        bus.D_Valid = 1'b0;
        chk("cap_on_boundary", 64'(hs), 64'd1);
        chk("cap_on_boundary_held", 64'(exp_q.size()), 64'd1);
        step(64 * 3);

        // DATA_W = 16 instance
        wait_cyc(5);
        l16 = 16'hA5A5;
        r16 = 16'h3C0F;
        chk("w16_ready", 64'(bus16.D_Ready), 64'd1);
        bus16.D_L = l16;
        bus16.D_R = r16;
        bus16.D_Valid = 1'b1;
        step(1);
        bus16.D_Valid = 1'b0;
        wait_cyc(63);
        step(1);
        exp16 = '0;
        for (int i = 0; i < 16; i++) begin
            exp16[1 + i]  = l16[15 - i];
            exp16[33 + i] = r16[15 - i];
        end
        for (int k = 0; k < 64; k++) begin
            @(negedge Sclk);
            chk("w16_sdata", 64'(sdata16), 64'(exp16[k]));
            @(posedge Sclk);
            #1;
        end

        step(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
